if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch stage with a decoupling fetch queue between instruction memory and decode. It owns the PC, resolves redirects from decode (branch, jump, jump-register) by fixed priority, streams instructions to ID over a valid/ready handshake and absorbs decode stalls without losing fetched words. It also provides an auto-incrementing program-load port and a sticky halt.

## Interface
- INST_SZ, 32, instruction width
- PC_SZ, 32, PC width (byte address)
- MEM_SZ, 10, log2 of memory depth in words
- FQ_DEPTH, 4, fetch-queue entries; power of two, ≥2
- RESET_PC, 0, PC after reset; word-aligned
---
- i_clk  in  1  clock
- i_reset  in  1  reset: i_reset, synchronous, active-high; clock i_clk
- i_enable  in  1  run enable
- i_write  in  1  program-load write strobe
- i_instruction  in  INST_SZ  program-load data
- i_pc_src  in  1  take branch
- i_branch_addr  in  PC_SZ  branch target (byte address)
- i_jump  in  1  take jump
- i_jump_addr  in  PC_SZ  jump target (byte address)
- i_jump_sel  in  1  take jump-register
- i_rs_addr  in  PC_SZ  GPR[rs] target
- i_ready  in  1  decode accepts head entry
- i_halt  in  1  halt request
- o_valid  out  1  head entry valid
- o_instruction  out  INST_SZ  head instruction
- o_pc  out  PC_SZ  address of head instruction
- o_npc  out  PC_SZ  o_pc + 4
- o_fq_count  out  $clog2(FQ_DEPTH)+1  occupied entries
- o_load_addr  out  MEM_SZ  next program-load word index
- o_halted  out  1  sticky halt status

## Operation
- Memory: 2^MEM_SZ words, synchronous read, indexed by fetch_pc[MEM_SZ+1:2]; upper PC bits ignored (address wraps).
- Load: write when i_write & ~i_enable; data stored at o_load_addr, which then increments, wrapping at 2^MEM_SZ. i_write ignored while i_enable=1.
- Issue: a read issues in a cycle iff i_enable & ~o_halted & (o_fq_count + inflight < FQ_DEPTH) & no redirect; fetch_pc += 4 on issue. inflight is 0 or 1.
- Fill: an in-flight read pushes {data, its pc} into the queue the following cycle.
- Transfer: entry pops when o_valid & i_ready & i_enable. o_valid = (count≠0) & i_enable.
- Redirect: any of i_jump_sel, i_jump, i_pc_src while i_enable. Target priority jump_sel (i_rs_addr & ~3) > jump (i_jump_addr & ~3) > branch (i_branch_addr & ~3). Effect at the edge: fetch_pc ← target; queue flushed except the entry transferring in that same cycle (the delay slot completes); an in-flight read is discarded.
- Halt: i_halt while i_enable sets o_halted at the next edge. Issue stops; in-flight read still lands; the queue keeps draining. Cleared only by reset.
- i_enable low: no issue, no pop, no redirect; in-flight read still lands.

## Timing
- Reset values: o_valid 0, o_fq_count 0, o_halted 0, o_load_addr 0, fetch_pc RESET_PC, inflight 0; o_pc/o_npc/o_instruction 0 while empty.
- Startup: first issue in the first enabled cycle N; o_valid=1 in N+2 with o_pc=RESET_PC.
- Steady state with i_ready=1: one instruction per cycle, consecutive o_pc values +4.
- Redirect in cycle N: target issued in N+1, visible at head in N+3.
- Full (count+inflight=FQ_DEPTH): no issue; a pop in the same cycle does not permit issue until the next cycle.
- Empty: o_valid=0; a push and no pop gives o_valid=1 next cycle.
- Reset mid-run overrides everything: queue, inflight, halt and load pointer cleared at the edge; memory contents retained.

## Test plan
- Load 8 words (0x1000_0000+i) with i_enable=0, i_write=1 → o_load_addr=8; enable, i_ready=1 → o_valid in cycle 2, instructions 0x1000_0000..07 with o_pc 0x0,0x4,… one per cycle.
- i_ready=0 from start, FQ_DEPTH=4 → o_fq_count saturates at 4, no issue; raise i_ready → four queued words emerge in order with no loss or duplication, then streaming resumes.
- In one cycle assert i_pc_src (0x40), i_jump (0x80), i_jump_sel (i_rs_addr=0xC3) with head transferring → that head completes, queue flushed, next o_valid 3 cycles later with o_pc=0xC0.
- Redirect while i_ready=0 and queue full → all 4 entries flushed, o_fq_count=0 next cycle, target fetched.
- i_halt at cycle 5 with i_ready=0 → o_halted=1 at cycle 6; count stops after in-flight lands; drain with i_ready=1 → o_valid falls to 0 and stays.
- Reset asserted mid-stream with 3 entries queued and o_halted=1 → next cycle o_valid=0, o_fq_count=0, o_halted=0; memory still holds loaded program, refetched from RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the PC and the instruction memory.
// A small fetch queue decouples memory reads from decode stalls and redirects.
module if_fetch_queue #(
  parameter int          INST_SZ  = 32,
  parameter int          PC_SZ    = 32,
  parameter int          MEM_SZ   = 10,
  parameter int          FQ_DEPTH = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic                          i_write,
  input  logic [INST_SZ-1:0]            i_instruction,
  input  logic                          i_pc_src,
  input  logic [PC_SZ-1:0]              i_branch_addr,
  input  logic                          i_jump,
  input  logic [PC_SZ-1:0]              i_jump_addr,
  input  logic                          i_jump_sel,
  input  logic [PC_SZ-1:0]              i_rs_addr,
  input  logic                          i_ready,
  input  logic                          i_halt,
  output logic                          o_valid,
  output logic [INST_SZ-1:0]            o_instruction,
  output logic [PC_SZ-1:0]              o_pc,
  output logic [PC_SZ-1:0]              o_npc,
  output logic [$clog2(FQ_DEPTH):0]     o_fq_count,
  output logic [MEM_SZ-1:0]             o_load_addr,
  output logic                          o_halted
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  logic [INST_SZ-1:0] mem [2**MEM_SZ];
  logic [INST_SZ-1:0] mem_rdata_q;
  logic [INST_SZ-1:0] fq_inst_q [FQ_DEPTH];
  logic [PC_SZ-1:0]   fq_pc_q   [FQ_DEPTH];

  logic [PC_SZ-1:0]  fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [PC_SZ-1:0]  inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              halted_q, halted_d;
  logic [MEM_SZ-1:0] load_addr_q, load_addr_d;

  logic              redirect, issue, push, pop, load_we, head_vld;
  logic [PC_SZ-1:0]  target;
  logic [CW:0]       occ;

  always_comb begin
    redirect = i_enable & (i_jump_sel | i_jump | i_pc_src);
    if (i_jump_sel)  target = i_rs_addr;
    else if (i_jump) target = i_jump_addr;
    else             target = i_branch_addr;
    target   = target & ~PC_SZ'(3);
    occ      = {1'b0, count_q} + (CW+1)'(inflight_q);
    // occupancy uses registered count, so a same-cycle pop never frees a slot early
    issue    = i_enable & ~halted_q & (occ < (CW+1)'(FQ_DEPTH)) & ~redirect;
    head_vld = (count_q != '0);
    o_valid  = head_vld & i_enable;
    pop      = o_valid & i_ready;
    push     = inflight_q & ~redirect;
    load_we  = i_write & ~i_enable & ~i_reset;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    halted_d      = halted_q | (i_halt & i_enable);
    load_addr_d   = load_addr_q + MEM_SZ'(load_we);
    if (redirect)   fetch_pc_d = target;
    else if (issue) fetch_pc_d = fetch_pc_q + PC_SZ'(4);
    if (redirect) begin
      // the transferring head leaves anyway; everything behind it is dropped
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_pc_q    <= PC_SZ'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      halted_q      <= 1'b0;
      load_addr_q   <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      halted_q      <= halted_d;
      load_addr_q   <= load_addr_d;
    end
  end

  // storage is not reset so the loaded program survives a reset
  always_ff @(posedge i_clk) begin
    if (load_we) mem[load_addr_q] <= i_instruction;
    if (issue)   mem_rdata_q <= mem[fetch_pc_q[MEM_SZ+1:2]];
    if (push) begin
      fq_inst_q[wr_ptr_q] <= mem_rdata_q;
      fq_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  always_comb begin
    o_instruction = head_vld ? fq_inst_q[rd_ptr_q] : '0;
    o_pc          = head_vld ? fq_pc_q[rd_ptr_q] : '0;
    o_npc         = head_vld ? fq_pc_q[rd_ptr_q] + PC_SZ'(4) : '0;
    o_fq_count    = count_q;
    o_load_addr   = load_addr_q;
    o_halted      = halted_q;
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: expected {pc, instruction} pairs are
// queued per scenario and popped as decode accepts heads.
module tb_if_fetch_queue;
  logic        i_clk = 1'b0;
  logic        i_reset, i_enable, i_write, i_pc_src, i_jump, i_jump_sel, i_ready, i_halt;
  logic [31:0] i_instruction, i_branch_addr, i_jump_addr, i_rs_addr;
  logic        o_valid, o_halted;
  logic [31:0] o_instruction, o_pc, o_npc;
  logic [2:0]  o_fq_count;
  logic [9:0]  o_load_addr;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;

  if_fetch_queue dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_write(i_write),
    .i_instruction(i_instruction), .i_pc_src(i_pc_src), .i_branch_addr(i_branch_addr),
    .i_jump(i_jump), .i_jump_addr(i_jump_addr), .i_jump_sel(i_jump_sel),
    .i_rs_addr(i_rs_addr), .i_ready(i_ready), .i_halt(i_halt), .o_valid(o_valid),
    .o_instruction(o_instruction), .o_pc(o_pc), .o_npc(o_npc), .o_fq_count(o_fq_count),
    .o_load_addr(o_load_addr), .o_halted(o_halted)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t x;
    x.pc = pc;
    x.inst = 32'h1000_0000 + (pc >> 2);
    sb.push_back(x);
  endtask

  task automatic do_reset();
    i_reset = 1; i_enable = 0; i_write = 0; i_pc_src = 0; i_jump = 0; i_jump_sel = 0;
    i_ready = 0; i_halt = 0; i_branch_addr = 0; i_jump_addr = 0; i_rs_addr = 0;
    sb.delete();
    step(); step();
    i_reset = 0;
  endtask

  task automatic test_reset();
    i_instruction = 0;
    do_reset();
    checks++;
    if ({o_valid, o_fq_count, o_halted, o_load_addr} !== 15'd0) begin
      failures++;
      $display("FAIL reset_state got v=%b cnt=%0d h=%b la=%0d exp all 0", o_valid, o_fq_count, o_halted, o_load_addr);
    end
    checks++;
    if ({o_pc, o_npc, o_instruction} !== 96'd0) begin
      failures++;
      $display("FAIL reset_head got pc=%h npc=%h inst=%h exp 0", o_pc, o_npc, o_instruction);
    end
  endtask

  task automatic test_load();
    i_enable = 0; i_write = 1;
    for (int i = 0; i < 64; i++) begin
      i_instruction = 32'h1000_0000 + i;
      step();
      if (i == 7) begin
        checks++;
        if (o_load_addr !== 10'd8) begin
          failures++; $display("FAIL load_addr8 got=%0d exp=8", o_load_addr);
        end
      end
    end
    checks++;
    if (o_load_addr !== 10'd64) begin
      failures++; $display("FAIL load_addr64 got=%0d exp=64", o_load_addr);
    end
    i_enable = 1; i_instruction = 32'hDEAD_BEEF;
    step();
    checks++;
    if (o_load_addr !== 10'd64) begin
      failures++; $display("FAIL load_ignored_enabled got=%0d exp=64", o_load_addr);
    end
    i_write = 0; i_enable = 0;
  endtask

  task automatic test_stream();
    do_reset();
    i_enable = 1; i_ready = 1;
    for (int k = 0; k < 10; k++) push_exp(32'(4 * k));
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      #1;
      checks++;
      if (c < 2) begin
        if (o_valid !== 1'b0) begin failures++; $display("FAIL stream_startup c=%0d valid=%b exp=0", c, o_valid); end
      end else begin
        e = sb.pop_front();
        if (o_valid !== 1'b1 || {o_pc, o_instruction, o_npc} !== {e.pc, e.inst, e.pc + 32'd4}) begin
          failures++;
          $display("FAIL stream c=%0d got v=%b pc=%h inst=%h npc=%h exp pc=%h inst=%h", c, o_valid, o_pc, o_instruction, o_npc, e.pc, e.inst);
        end
      end
      step();
    end
    i_enable = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    i_enable = 1; i_ready = 0;
    for (int k = 0; k < 10; k++) push_exp(32'(4 * k));
    for (int c = 0; c < 9; c++) begin
      #1;
      if (c == 4 || c >= 5) begin
        checks++;
        if (o_fq_count !== ((c == 4) ? 3'd3 : 3'd4)) begin
          failures++; $display("FAIL bp_count c=%0d got=%0d exp=%0d", c, o_fq_count, (c == 4) ? 3 : 4);
        end
      end
      step();
    end
    i_ready = 1;
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      #1;
      e = sb.pop_front();
      checks++;
      if (o_valid !== 1'b1 || {o_pc, o_instruction} !== {e.pc, e.inst}) begin
        failures++;
        $display("FAIL bp_drain c=%0d got v=%b pc=%h inst=%h exp pc=%h inst=%h", c, o_valid, o_pc, o_instruction, e.pc, e.inst);
      end
      step();
    end
    i_enable = 0;
  endtask

  task automatic test_redirect_priority();
    do_reset();
    i_enable = 1; i_ready = 1;
    i_branch_addr = 32'h40; i_jump_addr = 32'h80; i_rs_addr = 32'hC3;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    push_exp(32'hC0); push_exp(32'hC4); push_exp(32'hC8);
    for (int c = 0; c < 16 && sb.size() > 0; c++) begin
      i_pc_src = (c == 4); i_jump = (c == 4); i_jump_sel = (c == 4);
      #1;
      if (c == 5 || c == 6) begin
        checks++;
        if (o_valid !== 1'b0 || (c == 5 && o_fq_count !== 3'd0)) begin
          failures++; $display("FAIL redir_flush c=%0d got v=%b cnt=%0d exp v=0 cnt=0", c, o_valid, o_fq_count);
        end
      end else if (c >= 2) begin
        e = sb.pop_front();
        checks++;
        if (o_valid !== 1'b1 || {o_pc, o_instruction} !== {e.pc, e.inst}) begin
          failures++;
          $display("FAIL redir_prio c=%0d got v=%b pc=%h inst=%h exp pc=%h inst=%h", c, o_valid, o_pc, o_instruction, e.pc, e.inst);
        end
      end
      step();
    end
    i_pc_src = 0; i_jump = 0; i_jump_sel = 0; i_enable = 0;
  endtask

  task automatic test_redirect_full();
    do_reset();
    i_enable = 1; i_ready = 0;
    push_exp(32'h84); push_exp(32'h88); push_exp(32'h8C);
    repeat (6) step();
    i_jump = 1; i_jump_addr = 32'h85; i_pc_src = 1; i_branch_addr = 32'h200;
    #1;
    checks++;
    if (o_fq_count !== 3'd4) begin failures++; $display("FAIL rf_full got=%0d exp=4", o_fq_count); end
    step();
    i_jump = 0; i_pc_src = 0;
    #1;
    checks++;
    if (o_fq_count !== 3'd0 || o_valid !== 1'b0) begin
      failures++; $display("FAIL rf_flushed got cnt=%0d v=%b exp cnt=0 v=0", o_fq_count, o_valid);
    end
    step(); step();
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_pc !== sb[0].pc || o_instruction !== sb[0].inst) begin
      failures++; $display("FAIL rf_target got v=%b pc=%h inst=%h exp pc=%h inst=%h", o_valid, o_pc, o_instruction, sb[0].pc, sb[0].inst);
    end
    i_ready = 1;
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      #1;
      e = sb.pop_front();
      checks++;
      if (o_valid !== 1'b1 || {o_pc, o_instruction} !== {e.pc, e.inst}) begin
        failures++; $display("FAIL rf_drain c=%0d got pc=%h inst=%h exp pc=%h inst=%h", c, o_pc, o_instruction, e.pc, e.inst);
      end
      step();
    end
    i_enable = 0;
  endtask

  task automatic test_halt();
    do_reset();
    i_enable = 1; i_ready = 0;
    for (int c = 0; c < 8; c++) begin
      i_halt = (c == 2);
      #1;
      if (c == 2 || c == 3) begin
        checks++;
        if (o_halted !== (c == 3)) begin failures++; $display("FAIL halt_flag c=%0d got=%b exp=%b", c, o_halted, c == 3); end
      end
      if (c == 4 || c == 7) begin
        checks++;
        if (o_fq_count !== 3'd3) begin failures++; $display("FAIL halt_count c=%0d got=%0d exp=3", c, o_fq_count); end
      end
      step();
    end
    i_ready = 1;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (o_valid !== 1'b1 || {o_pc, o_instruction} !== {e.pc, e.inst}) begin
          failures++; $display("FAIL halt_drain c=%0d got v=%b pc=%h exp pc=%h", c, o_valid, o_pc, e.pc);
        end
      end else if (o_valid !== 1'b0 || o_halted !== 1'b1) begin
        failures++; $display("FAIL halt_stays c=%0d got v=%b h=%b exp v=0 h=1", c, o_valid, o_halted);
      end
      step();
    end
    i_enable = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_enable = 1; i_ready = 0;
    for (int c = 0; c < 6; c++) begin
      i_halt = (c == 2);
      step();
    end
    #1;
    checks++;
    if (o_fq_count !== 3'd3 || o_halted !== 1'b1) begin
      failures++; $display("FAIL rm_pre got cnt=%0d h=%b exp cnt=3 h=1", o_fq_count, o_halted);
    end
    i_reset = 1;
    step();
    i_reset = 0; i_ready = 1;
    #1;
    checks++;
    if ({o_valid, o_fq_count, o_halted, o_load_addr} !== 15'd0) begin
      failures++; $display("FAIL rm_cleared got v=%b cnt=%0d h=%b la=%0d exp all 0", o_valid, o_fq_count, o_halted, o_load_addr);
    end
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      #1;
      checks++;
      if (c < 2) begin
        if (o_valid !== 1'b0) begin failures++; $display("FAIL rm_startup c=%0d v=%b exp=0", c, o_valid); end
      end else begin
        e = sb.pop_front();
        if (o_valid !== 1'b1 || {o_pc, o_instruction} !== {e.pc, e.inst}) begin
          failures++; $display("FAIL rm_refetch c=%0d got v=%b pc=%h inst=%h exp pc=%h inst=%h", c, o_valid, o_pc, o_instruction, e.pc, e.inst);
        end
      end
      step();
    end
    i_enable = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream();
    test_backpressure();
    test_redirect_priority();
    test_redirect_full();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
